// File: rtl/rf_alu_pkg.sv
// rf_alu_pkg: shared opcodes, field positions, FSM states and control word for the RF+ALU sequencer
package rf_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBB = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4, OP_SUBI = 4'd5, OP_LDI = 4'd6, OP_NOP = 4'hF;
  localparam int OP_LSB = 12, RD_LSB = 9, RA_LSB = 6, RB_LSB = 3, IMM5_W = 5, IMM8_W = 8;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  typedef struct packed {
    logic adc;
    logic sub;
    logic sbb;
    logic src_b;
    logic use_c;
    logic wr;
    logic is_ldi;
    logic legal;
  } ctrl_t;
endpackage

// File: rtl/rf_alu_decode.sv
// rf_alu_decode: maps a 4-bit opcode onto the sequencer control word
module rf_alu_decode import rf_alu_pkg::*; (
  input  logic [3:0] op,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.legal = op <= OP_LDI || op == OP_NOP;
    ctrl.adc = op == OP_ADC;
    ctrl.sub = op == OP_SUB || op == OP_SUBI;
    ctrl.sbb = op == OP_SBB;
    ctrl.src_b = op == OP_ADDI || op == OP_SUBI;
    ctrl.use_c = op == OP_ADC || op == OP_SBB;
    ctrl.wr = op <= OP_LDI;
    ctrl.is_ldi = op == OP_LDI;
  end
endmodule

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: accept/exec/writeback micro-sequencer driving the RF_plus_ALU control ports
module rf_alu_sequencer import rf_alu_pkg::*; #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          done,
  output logic          illegal,
  output logic [3:0]    flags_q,
  output logic [AW-1:0] Read_Addr_A,
  output logic [AW-1:0] Read_Addr_B,
  output logic [AW-1:0] Write_Addr,
  output logic [DW-1:0] Write_Data,
  output logic          Write_En,
  output logic          Pre_C,
  output logic          Src_ALU_B,
  output logic          ADC,
  output logic          SUB,
  output logic          SBB,
  output logic [4:0]    imm5,
  input  logic [DW-1:0] Y,
  input  logic          Z,
  input  logic          N,
  input  logic          C,
  input  logic          V
);
  state_t state_q, state_d;
  ctrl_t ctrl_q, ctrl_d, ctrl_in;
  logic [OP_LSB-1:0] ir_q, ir_d;
  logic [DW-1:0] result_q, result_d;
  logic [3:0] flags_d;
  logic illegal_q, illegal_d, exec, wb;
  rf_alu_decode u_dec (.op(instr[OP_LSB +: 4]), .ctrl(ctrl_in));
  assign exec = state_q == EXEC;
  assign wb = state_q == WB;
  assign instr_ready = state_q == IDLE && !illegal_q;
  assign illegal = illegal_q;
  assign done = !clr && (wb || (exec && ctrl_q.legal && !ctrl_q.wr));
  assign Read_Addr_A = exec ? ir_q[RA_LSB +: AW] : '0;
  assign Read_Addr_B = exec ? ir_q[RB_LSB +: AW] : '0;
  assign ADC = exec && ctrl_q.adc;
  assign SUB = exec && ctrl_q.sub;
  assign SBB = exec && ctrl_q.sbb;
  assign Src_ALU_B = exec && ctrl_q.src_b;
  assign Pre_C = exec && ctrl_q.use_c && flags_q[1];
  assign imm5 = exec ? ir_q[IMM5_W-1:0] : '0;
  assign Write_En = wb && !clr;
  assign Write_Addr = wb ? ir_q[RD_LSB +: AW] : '0;
  assign Write_Data = wb ? result_q : '0;
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    ir_d = ir_q;
    result_d = result_q;
    flags_d = flags_q;
    illegal_d = 1'b0;
    if (instr_valid && instr_ready) begin
      ir_d = instr[OP_LSB-1:0];
      ctrl_d = ctrl_in;
      state_d = ctrl_in.legal ? EXEC : IDLE;
      illegal_d = !ctrl_in.legal;
    end else if (exec) begin
      state_d = ctrl_q.wr ? WB : IDLE;
      result_d = ctrl_q.is_ldi ? {{(DW-IMM8_W){1'b0}}, ir_q[IMM8_W-1:0]} : Y;
      flags_d = ctrl_q.wr && !ctrl_q.is_ldi ? {Z, N, C, V} : flags_q;
    end else if (wb) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      ir_q <= '0;
      result_q <= '0;
      flags_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      ir_q <= ir_d;
      result_q <= result_d;
      flags_q <= flags_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_rf_alu_sequencer.sv
// tb_rf_alu_sequencer: table-driven check of the sequencer against a behavioural RF+ALU
module tb_rf_alu_sequencer;
  logic clk = 1'b0, clr = 1'b1, instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic instr_ready, done, illegal, Write_En, Pre_C, Src_ALU_B, ADC, SUB, SBB;
  logic [3:0] flags_q;
  logic [2:0] Read_Addr_A, Read_Addr_B, Write_Addr;
  logic [15:0] Write_Data, Y;
  logic [4:0] imm5;
  logic Z, N, C, V;
  logic [15:0] rf [8];
  logic [15:0] a, b, bb;
  logic [16:0] s;
  logic cin;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rf_alu_sequencer #(.DW(16), .AW(3)) dut (
    .clk(clk), .clr(clr), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .done(done), .illegal(illegal), .flags_q(flags_q), .Read_Addr_A(Read_Addr_A),
    .Read_Addr_B(Read_Addr_B), .Write_Addr(Write_Addr), .Write_Data(Write_Data),
    .Write_En(Write_En), .Pre_C(Pre_C), .Src_ALU_B(Src_ALU_B), .ADC(ADC), .SUB(SUB),
    .SBB(SBB), .imm5(imm5), .Y(Y), .Z(Z), .N(N), .C(C), .V(V)
  );
  always @(posedge clk) if (Write_En) rf[Write_Addr] <= Write_Data;
  always_comb begin
    a = rf[Read_Addr_A];
    b = Src_ALU_B ? {11'b0, imm5} : rf[Read_Addr_B];
    bb = (SUB || SBB) ? ~b : b;
    cin = SUB ? 1'b1 : (ADC || SBB) ? Pre_C : 1'b0;
    s = {1'b0, a} + {1'b0, bb} + {16'b0, cin};
    Y = s[15:0];
    C = s[16];
    Z = s[15:0] == 16'h0;
    N = s[15];
    V = (a[15] == bb[15]) && (s[15] != a[15]);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    for (int k = 0; k < 10 && !instr_ready; k++) step();
    check("ready_wait", instr_ready, 1);
  endtask
  typedef struct {
    logic [15:0] instr;
    logic [2:0] ra, rb;
    logic [4:0] ctl;
    logic [4:0] imm;
    logic [2:0] wa;
    logic [15:0] wd;
    logic [3:0] fl;
  } vec_t;
  vec_t vt [9];
  initial begin
    vt[0] = '{16'h6034, 3'd0, 3'd6, 5'b00000, 5'd0, 3'd0, 16'h0034, 4'b0000};
    vt[1] = '{16'h6245, 3'd1, 3'd0, 5'b00000, 5'd0, 3'd1, 16'h0045, 4'b0000};
    vt[2] = '{16'h0408, 3'd0, 3'd1, 5'b00000, 5'd0, 3'd2, 16'h0079, 4'b0000};
    vt[3] = '{16'h2608, 3'd0, 3'd1, 5'b01000, 5'd0, 3'd3, 16'hFFEF, 4'b0100};
    vt[4] = '{16'h3808, 3'd0, 3'd1, 5'b00100, 5'd0, 3'd4, 16'hFFEE, 4'b0100};
    vt[5] = '{16'h2C40, 3'd1, 3'd0, 5'b01000, 5'd0, 3'd6, 16'h0011, 4'b0010};
    vt[6] = '{16'h1E08, 3'd0, 3'd1, 5'b10001, 5'd0, 3'd7, 16'h007A, 4'b0000};
    vt[7] = '{16'h4A0A, 3'd0, 3'd1, 5'b00010, 5'd10, 3'd5, 16'h003E, 4'b0000};
    vt[8] = '{16'h5B43, 3'd5, 3'd0, 5'b01010, 5'd3, 3'd5, 16'h003B, 4'b0010};
    repeat (2) step();
    clr = 1'b0;
    check("rst_ready", instr_ready, 1);
    check("rst_flags", flags_q, 0);
    check("rst_we", Write_En, 0);
    check("rst_done_ill", {done, illegal}, 0);
    check("rst_ctl", {ADC, SUB, SBB, Src_ALU_B, Pre_C, Read_Addr_A, Read_Addr_B}, 0);
    foreach (vt[i]) begin
      wait_ready();
      instr = vt[i].instr;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      check($sformatf("v%0d_exec_ready", i), instr_ready, 0);
      check($sformatf("v%0d_ra", i), Read_Addr_A, vt[i].ra);
      check($sformatf("v%0d_rb", i), Read_Addr_B, vt[i].rb);
      check($sformatf("v%0d_ctl", i), {ADC, SUB, SBB, Src_ALU_B, Pre_C}, vt[i].ctl);
      if (vt[i].ctl[1]) check($sformatf("v%0d_imm5", i), imm5, vt[i].imm);
      check($sformatf("v%0d_exec_we_done", i), {Write_En, done}, 0);
      step();
      check($sformatf("v%0d_wb_we_done", i), {Write_En, done}, 2'b11);
      check($sformatf("v%0d_wa", i), Write_Addr, vt[i].wa);
      check($sformatf("v%0d_wd", i), Write_Data, vt[i].wd);
      check($sformatf("v%0d_flags", i), flags_q, vt[i].fl);
      check($sformatf("v%0d_wb_ctl", i), {ADC, SUB, SBB, Src_ALU_B, Pre_C}, 0);
      step();
    end
    wait_ready();
    instr = 16'hE000;
    instr_valid = 1'b1;
    step();
    check("ill_pulse", illegal, 1);
    check("ill_not_ready", instr_ready, 0);
    check("ill_no_done_we", {done, Write_En}, 0);
    instr = 16'h6411;
    step();
    check("ill_once", illegal, 0);
    check("ill_ready_again", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    check("ill_next_accepted", instr_ready, 0);
    step();
    check("ill_next_wb", {Write_En, Write_Addr, Write_Data}, {1'b1, 3'd2, 16'h0011});
    check("ill_flags_kept", flags_q, 4'b0010);
    step();
    wait_ready();
    instr = 16'hF000;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("nop_done", {done, Write_En}, 2'b10);
    step();
    check("nop_idle", {instr_ready, done, Write_En}, 3'b100);
    check("nop_flags", flags_q, 4'b0010);
    instr = 16'h0408;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("abort_in_exec", instr_ready, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("abort_no_we_done", {Write_En, done}, 0);
    check("abort_flags", flags_q, 0);
    step();
    check("abort_ready", instr_ready, 1);
    check("abort_idle", {Write_En, done, flags_q}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
Micro-sequencer that drives the register-file-plus-ALU datapath (RF_plus_ALU) from its control side. It accepts 16-bit instructions over a valid/ready handshake and decodes them. It then drives the RF read addresses and the ALU mode controls, captures Y and the Z/N/C/V flags, and writes the result back into the RF. It sits between the instruction source (fetch/testbench) and RF_plus_ALU, and is the initiator for every port RF_plus_ALU exposes.

Parameters:
DW, 16, datapath / instruction width
AW, 3, RF address width (8 registers)

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, synchronous, active-high
instr  in  DW  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  sequencer idle; instr accepted when valid&ready
done  out  1  1-cycle pulse: instruction retired
illegal  out  1  1-cycle pulse: undefined opcode dropped
flags_q  out  4  registered {Z,N,C,V}
Read_Addr_A  out  AW  to RF_plus_ALU
Read_Addr_B  out  AW  to RF_plus_ALU
Write_Addr  out  AW  to RF_plus_ALU
Write_Data  out  DW  to RF_plus_ALU
Write_En  out  1  to RF_plus_ALU
Pre_C  out  1  ALU carry-in
Src_ALU_B  out  1  1 = imm5 as ALU B operand
ADC, SUB, SBB  out  1 each  ALU mode selects (all 0 = ADD)
imm5  out  5  immediate to ALU
Y  in  DW  ALU result
Z, N, C, V  in  1 each  ALU flags

Behaviour:
- Reset: clk is the single clock; clr is synchronous, active-high. On clr: state=IDLE, flags_q=0, all datapath outputs 0, done=illegal=0, instr_ready=1 in the following cycle.
- Encoding: op[15:12], rd[11:9], ra[8:6], rb[5:3], imm5[4:0], imm8[7:0].
- Opcodes:
  - 0 ADD: rd=ra+rb
  - 1 ADC: rd=ra+rb+C
  - 2 SUB: rd=ra-rb
  - 3 SBB: rd=ra-rb with carry
  - 4 ADDI: rd=ra+imm5
  - 5 SUBI: rd=ra-imm5
  - 6 LDI: rd={8'h00,imm8}
  - 15 NOP
  - Any other opcode is illegal.
- States:
  - IDLE: instr_ready=1. On valid&ready, latch instr. Next state is EXEC, or IDLE with illegal=1 in the next cycle for an illegal opcode.
  - EXEC, 1 cycle:
    - Read_Addr_A=ra, Read_Addr_B=rb.
    - ADC/SUB/SBB one-hot per op (ADDI = ADD mode, SUBI = SUB mode).
    - Src_ALU_B=1 for ADDI/SUBI; imm5=field.
    - Pre_C=flags_q.C for ADC/SBB, else 0.
    - At the clock edge, capture Y into a result register. Arithmetic ops also load flags_q from {Z,N,C,V}.
    - LDI: result={8'h00,imm8}, flags unchanged.
    - NOP: skip to IDLE with done=1.
  - WB, 1 cycle: Write_En=1, Write_Addr=rd, Write_Data=result, done=1. Next state IDLE.
- Outside EXEC, ALU controls, Src_ALU_B and Pre_C are 0. Write_En is 1 only in WB.
- Latency: accept in cycle n, EXEC n+1, WB/done n+2, next accept n+3. Sustained throughput is 1 instruction per 3 cycles.
- instr is ignored while instr_ready=0; there is no buffering.
- rd==ra or rd==rb is safe, because the result is registered before writeback.
- clr in EXEC or WB aborts the instruction: no Write_En, no done, and flags_q is cleared.
- illegal and done are never asserted together.

Decomposition:
- Package rf_alu_pkg:
  - opcode constants
  - state enum {IDLE,EXEC,WB}
  - field bit positions
  - control-word typedef {adc,sub,sbb,src_b,use_c,wr,is_ldi,legal}
- One combinational sub-module, rf_alu_decode: opcode -> control word. The FSM, result register and flags register stay in rf_alu_sequencer.

Test Plan:
- LDI R0,0x34; LDI R1,0x45 -> Write_En pulses with Write_Addr 0 / Write_Data 0x0034, then 1 / 0x0045; flags_q stays 0; each done pulse lands 2 cycles after acceptance.
- ADD R2,R0,R1 -> in EXEC: ADC=SUB=SBB=0, Pre_C=0, Read_Addr_A=0, Read_Addr_B=1; in WB: Write_Data=0x0079, Write_Addr=2; flags_q equals the ALU {Z,N,C,V} sampled in EXEC.
- SUB R3,R0,R1, then SBB R4,R0,R1 -> SUB=1 / Write_Data 0xFFEF / flags_q.N=1; in the SBB EXEC cycle, SBB=1 and Pre_C equals the flags_q.C stored by the SUB.
- ADDI R5,R0,#10 -> Src_ALU_B=1, imm5=5'd10, Write_Data=0x003E; Src_ALU_B returns to 0 in WB.
- Opcode 0xE with instr_valid held high -> illegal pulses once, Write_En never asserts, flags_q unchanged; the next valid instruction is accepted 2 cycles after the first acceptance.
- ADD issued, clr asserted in its EXEC cycle -> no Write_En and no done; flags_q=0 and instr_ready=1 the cycle after clr deasserts.
